// File: rtl/qroute_defs_pkg.sv
// Shared Q-routing node definitions: word width, neighbor-table layout and
// the neighbor-scan FSM state encoding.
package qroute_defs;

    localparam int WORD_WIDTH = 16;

    typedef logic [WORD_WIDTH-1:0] word_t;

    localparam word_t TABLE_BASE_DEFAULT = 16'h0100;
    localparam word_t QVAL_MAX           = 16'hFFFF;

    // Each neighbor entry is three consecutive words: id, qvalue, hop.
    localparam int ENTRY_STRIDE = 3;
    localparam int OFF_ID       = 0;
    localparam int OFF_Q        = 1;
    localparam int OFF_HOP      = 2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_REQ,
        S_CNT_A,
        S_CNT_D,
        S_ID_A,
        S_ID_D,
        S_Q_A,
        S_Q_D,
        S_HOP_A,
        S_HOP_D,
        S_DONE
    } scan_state_t;

endpackage

// File: rtl/neighbor_scan_nbr_compare.sv
// Combinational per-entry judgement against the running best and this node.
// With SELF_FILTER_EN defined, entries carrying this node's own ID are ineligible.
module nbr_compare
    import qroute_defs::*;
(
    input  logic [WORD_WIDTH-1:0] entry_id,
    input  logic [WORD_WIDTH-1:0] entry_qvalue,
    input  logic [WORD_WIDTH-1:0] run_qvalue,
    input  logic [WORD_WIDTH-1:0] my_qvalue,
    input  logic [WORD_WIDTH-1:0] my_node_id,
    output logic                  eligible,
    output logic                  replace,
    output logic                  better
);

`ifdef SELF_FILTER_EN
    assign eligible = (entry_id != my_node_id);
`else
    logic unused_ids;
    assign unused_ids = ^{entry_id, my_node_id};
    assign eligible   = 1'b1;
`endif

    // Strict less-than: on a tie the earlier (lower-index) entry stays best.
    assign replace = eligible && (entry_qvalue < run_qvalue);
    assign better  = eligible && (entry_qvalue < my_qvalue);

endmodule

// File: rtl/neighbor_scan.sv
// Walks the neighbor table in shared node memory and reduces it to the best
// neighbor plus a better-than-self count. Optional macro: SELF_FILTER_EN.
module neighbor_scan
    import qroute_defs::*;
#(
    parameter logic [WORD_WIDTH-1:0] TABLE_BASE = TABLE_BASE_DEFAULT,
    parameter int                    MAX_NBR    = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] my_qvalue,
    input  logic [WORD_WIDTH-1:0] my_node_id,
    output logic                  mem_req,
    input  logic                  mem_gnt,
    output logic [WORD_WIDTH-1:0] mem_address,
    input  logic [WORD_WIDTH-1:0] mem_data_out,
    output logic [WORD_WIDTH-1:0] best_id,
    output logic [WORD_WIDTH-1:0] best_qvalue,
    output logic [WORD_WIDTH-1:0] best_hop,
    output logic [WORD_WIDTH-1:0] better_count,
    output logic                  best_valid,
    output logic                  busy,
    output logic                  done
);

    localparam word_t MAX_N = word_t'(MAX_NBR);

    scan_state_t state, state_next;

    word_t my_q_r, my_id_r;
    word_t n_eff, nbr_idx;
    word_t cur_id, cur_q;
    word_t acc_id, acc_q, acc_hop, acc_count;
    logic  acc_valid;
    word_t addr_hold;

    logic  cap_cnt, cap_id, cap_q, cap_hop, load_out;
    logic  is_last;
    logic  cmp_eligible, cmp_replace, cmp_better;

    word_t fin_id, fin_q, fin_hop, fin_count;
    logic  fin_valid;

    function automatic word_t field_addr(input word_t idx, input int off);
        return TABLE_BASE + WORD_WIDTH'(1 + off) + WORD_WIDTH'(ENTRY_STRIDE) * idx;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    assign is_last = ((nbr_idx + word_t'(1)) == n_eff);

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        cap_cnt    = 1'b0;
        cap_id     = 1'b0;
        cap_q      = 1'b0;
        cap_hop    = 1'b0;
        load_out   = 1'b0;
        mem_req    = 1'b0;
        busy       = (state != S_IDLE);
        done       = 1'b0;
        case (state)
            S_IDLE:  if (start) state_next = S_REQ;
            S_REQ: begin
                mem_req = 1'b1;
                if (mem_gnt) state_next = S_CNT_A;
            end
            S_CNT_A: begin
                mem_req = 1'b1;
                if (mem_gnt) state_next = S_CNT_D;
            end
            S_CNT_D: begin
                mem_req = 1'b1;
                if (mem_gnt) begin
                    cap_cnt = 1'b1;
                    if (mem_data_out == '0) begin
                        state_next = S_DONE;
                        load_out   = 1'b1;
                    end else begin
                        state_next = S_ID_A;
                    end
                end
            end
            S_ID_A: begin
                mem_req = 1'b1;
                if (mem_gnt) state_next = S_ID_D;
            end
            S_ID_D: begin
                mem_req = 1'b1;
                if (mem_gnt) begin
                    cap_id     = 1'b1;
                    state_next = S_Q_A;
                end
            end
            S_Q_A: begin
                mem_req = 1'b1;
                if (mem_gnt) state_next = S_Q_D;
            end
            S_Q_D: begin
                mem_req = 1'b1;
                if (mem_gnt) begin
                    cap_q      = 1'b1;
                    state_next = S_HOP_A;
                end
            end
            S_HOP_A: begin
                mem_req = 1'b1;
                if (mem_gnt) state_next = S_HOP_D;
            end
            S_HOP_D: begin
                mem_req = 1'b1;
                if (mem_gnt) begin
                    cap_hop = 1'b1;
                    if (is_last) begin
                        state_next = S_DONE;
                        load_out   = 1'b1;
                    end else begin
                        state_next = S_ID_A;
                    end
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // The address is live only in *_A states; elsewhere the last one is replayed.
    always_comb begin
        case (state)
            S_CNT_A: mem_address = TABLE_BASE;
            S_ID_A:  mem_address = field_addr(nbr_idx, OFF_ID);
            S_Q_A:   mem_address = field_addr(nbr_idx, OFF_Q);
            S_HOP_A: mem_address = field_addr(nbr_idx, OFF_HOP);
            default: mem_address = addr_hold;
        endcase
    end

    nbr_compare u_compare (
        .entry_id     (cur_id),
        .entry_qvalue (cur_q),
        .run_qvalue   (acc_q),
        .my_qvalue    (my_q_r),
        .my_node_id   (my_id_r),
        .eligible     (cmp_eligible),
        .replace      (cmp_replace),
        .better       (cmp_better)
    );

    // Accumulators including the entry being finished this cycle, if any.
    always_comb begin
        fin_id    = acc_id;
        fin_q     = acc_q;
        fin_hop   = acc_hop;
        fin_count = acc_count;
        fin_valid = acc_valid;
        if (state == S_HOP_D) begin
            fin_valid = acc_valid | cmp_eligible;
            if (cmp_replace) begin
                fin_id  = cur_id;
                fin_q   = cur_q;
                fin_hop = mem_data_out;
            end
            if (cmp_better && (acc_count != QVAL_MAX)) fin_count = acc_count + word_t'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            my_q_r       <= '0;
            my_id_r      <= '0;
            n_eff        <= '0;
            nbr_idx      <= '0;
            cur_id       <= '0;
            cur_q        <= '0;
            acc_id       <= '0;
            acc_q        <= QVAL_MAX;
            acc_hop      <= '0;
            acc_count    <= '0;
            acc_valid    <= 1'b0;
            addr_hold    <= '0;
            best_id      <= '0;
            best_qvalue  <= QVAL_MAX;
            best_hop     <= '0;
            better_count <= '0;
            best_valid   <= 1'b0;
        end else begin
            addr_hold <= mem_address;
            if ((state == S_IDLE) && start) begin
                my_q_r    <= my_qvalue;
                my_id_r   <= my_node_id;
                nbr_idx   <= '0;
                acc_id    <= '0;
                acc_q     <= QVAL_MAX;
                acc_hop   <= '0;
                acc_count <= '0;
                acc_valid <= 1'b0;
            end
            if (cap_cnt) n_eff <= (mem_data_out > MAX_N) ? MAX_N : mem_data_out;
            if (cap_id)  cur_id <= mem_data_out;
            if (cap_q)   cur_q  <= mem_data_out;
            if (cap_hop) begin
                acc_id    <= fin_id;
                acc_q     <= fin_q;
                acc_hop   <= fin_hop;
                acc_count <= fin_count;
                acc_valid <= fin_valid;
                nbr_idx   <= nbr_idx + word_t'(1);
            end
            if (load_out) begin
                best_id      <= fin_id;
                best_qvalue  <= fin_q;
                best_hop     <= fin_hop;
                better_count <= fin_count;
                best_valid   <= fin_valid;
            end
        end
    end

endmodule

// File: tb/tb_neighbor_scan.sv
// Bench for neighbor_scan: directed table cases with literal results, then
// randomized tables and grant patterns checked every cycle against a table-level model.
module tb_neighbor_scan;

    localparam int MAX_NBR = 16;

    logic        clock = 1'b0;
    logic        reset, start, mem_gnt;
    logic [15:0] my_qvalue, my_node_id;
    logic        mem_req, best_valid, busy, done;
    logic [15:0] mem_address, mem_data_out;
    logic [15:0] best_id, best_qvalue, best_hop, better_count;

    logic [15:0] tbl [0:127];

    int n_vec = 0;
    int n_err = 0;
    bit checking = 1'b0;
    bit rand_gnt = 1'b0;

    // Reference model state
    bit          m_busy = 1'b0, m_done = 1'b0;
    int          grants_left = 0;
    logic [15:0] e_id, e_q, e_hop, e_cnt;
    logic        e_valid;
    logic [15:0] p_id, p_q, p_hop, p_cnt;
    logic        p_valid;
    bit          hold_pending = 1'b0;
    logic [15:0] held_addr;

    neighbor_scan #(.TABLE_BASE(16'h0100), .MAX_NBR(MAX_NBR)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .my_qvalue    (my_qvalue),
        .my_node_id   (my_node_id),
        .mem_req      (mem_req),
        .mem_gnt      (mem_gnt),
        .mem_address  (mem_address),
        .mem_data_out (mem_data_out),
        .best_id      (best_id),
        .best_qvalue  (best_qvalue),
        .best_hop     (best_hop),
        .better_count (better_count),
        .best_valid   (best_valid),
        .busy         (busy),
        .done         (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] rd(input logic [15:0] a);
        int idx;
        idx = int'(a) - 256;
        if (idx >= 0 && idx < 128) return tbl[idx[6:0]];
        return 16'hDEAD;
    endfunction

    always @(posedge clock) mem_data_out <= rd(mem_address);

    always @(posedge clock) begin
        if (rand_gnt) begin
            #2;
            mem_gnt = ($urandom_range(0, 3) != 0);
        end
    end

    // Table-level expectation: best entry by strict minimum, count of entries below my_q.
    function automatic void model_scan(input logic [15:0] myq, input logic [15:0] myid,
                                       output logic [15:0] bid, output logic [15:0] bq,
                                       output logic [15:0] bh, output logic [15:0] bc,
                                       output logic bv, output int n_scan);
        n_scan = (int'(tbl[0]) > MAX_NBR) ? MAX_NBR : int'(tbl[0]);
        bid = 16'd0; bq = 16'hFFFF; bh = 16'd0; bc = 16'd0; bv = 1'b0;
        for (int k = 0; k < n_scan; k++) begin
            logic [15:0] id, q, hop;
            bit elig;
            id  = tbl[1 + 3*k];
            q   = tbl[2 + 3*k];
            hop = tbl[3 + 3*k];
`ifdef SELF_FILTER_EN
            elig = (id != myid);
`else
            elig = 1'b1;
`endif
            if (elig) begin
                bv = 1'b1;
                if (q < bq) begin bid = id; bq = q; bh = hop; end
                if (q < myq && bc != 16'hFFFF) bc = bc + 16'd1;
            end
        end
    endfunction

    // The scan needs one granted cycle per word-step (3 + 6*N'), then shows done.
    always @(posedge clock) begin
        int n_scan;
        if (reset) begin
            m_busy = 1'b0; m_done = 1'b0; grants_left = 0;
            e_id = 16'd0; e_q = 16'hFFFF; e_hop = 16'd0; e_cnt = 16'd0; e_valid = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0;
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (start) begin
                model_scan(my_qvalue, my_node_id, p_id, p_q, p_hop, p_cnt, p_valid, n_scan);
                grants_left = 3 + 6 * n_scan;
                m_busy = 1'b1;
            end
        end else if (mem_gnt) begin
            grants_left--;
            if (grants_left == 0) begin
                m_done = 1'b1;
                e_id = p_id; e_q = p_q; e_hop = p_hop; e_cnt = p_cnt; e_valid = p_valid;
            end
        end
    end

    always @(negedge clock) begin
        if (checking) begin
            check("done", done, m_done);
            check("busy", busy, m_busy);
            check("mem_req", mem_req, m_busy && !m_done);
            check("best_id", best_id, e_id);
            check("best_qvalue", best_qvalue, e_q);
            check("best_hop", best_hop, e_hop);
            check("better_count", better_count, e_cnt);
            check("best_valid", best_valid, e_valid);
            if (hold_pending && m_busy && !m_done) check("addr_hold", mem_address, held_addr);
            hold_pending = m_busy && !m_done && !mem_gnt && !reset;
            held_addr    = mem_address;
        end
    end

    task automatic load_case1();
        tbl[0] = 16'd3;
        tbl[1] = 16'd4; tbl[2] = 16'd9; tbl[3] = 16'd2;
        tbl[4] = 16'd7; tbl[5] = 16'd3; tbl[6] = 16'd5;
        tbl[7] = 16'd2; tbl[8] = 16'd6; tbl[9] = 16'd1;
    endtask

    // Starts a scan; cycles = posedges after the start edge until done is seen.
    task automatic run_scan(input int stall_at, input int stall_len, input int reset_at,
                            input logic [15:0] stall_addr, output int cycles);
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start  = 1'b0;
        cycles = 0;
        while (!done && cycles < 400) begin
            @(posedge clock);
            #1;
            cycles++;
            if (stall_len > 0 && cycles >= stall_at && cycles <= stall_at + stall_len)
                check("stall_address", mem_address, stall_addr);
            if (cycles == stall_at) mem_gnt = 1'b0;
            if (cycles == stall_at + stall_len) mem_gnt = 1'b1;
            if (reset_at > 0 && cycles == reset_at) reset = 1'b1;
            if (reset_at > 0 && cycles == reset_at + 1) begin
                reset = 1'b0;
                check("reset_mem_req", mem_req, 1'b0);
                check("reset_busy", busy, 1'b0);
                return;
            end
        end
        if (!done) check("done_timeout", 32'd0, 32'd1);
        @(posedge clock);
        #1;
    endtask

    task automatic check_results(input string tag, input int cycles, input int exp_cycles,
                                 input logic [15:0] id, input logic [15:0] q, input logic [15:0] hop,
                                 input logic [15:0] cnt, input logic valid);
        check({tag, "_latency"}, cycles, exp_cycles);
        check({tag, "_best_id"}, best_id, id);
        check({tag, "_best_qvalue"}, best_qvalue, q);
        check({tag, "_best_hop"}, best_hop, hop);
        check({tag, "_better_count"}, better_count, cnt);
        check({tag, "_best_valid"}, best_valid, valid);
    endtask

    initial begin
        int cyc;
        bit seen;
        reset = 1'b1; start = 1'b0; mem_gnt = 1'b1;
        my_qvalue = 16'd0; my_node_id = 16'd0;
        for (int i = 0; i < 128; i++) tbl[i] = 16'd0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_done", done, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_best_qvalue", best_qvalue, 16'hFFFF);
        check("rst_best_id", best_id, 16'd0);
        check("rst_better_count", better_count, 16'd0);
        check("rst_best_valid", best_valid, 1'b0);
        check("rst_mem_address", mem_address, 16'd0);
        reset = 1'b0;
        checking = 1'b1;

        // Case 1: basic three-entry table
        load_case1();
        my_qvalue = 16'd5; my_node_id = 16'd0;
        run_scan(0, 0, 0, 16'd0, cyc);
        check_results("case1", cyc, 21, 16'd7, 16'd3, 16'd5, 16'd1, 1'b1);

        // Case 2: empty table
        tbl[0] = 16'd0;
        run_scan(0, 0, 0, 16'd0, cyc);
        check_results("empty", cyc, 3, 16'd0, 16'hFFFF, 16'd0, 16'd0, 1'b0);

        // Case 3: equal Q-values keep the earlier entry
        tbl[0] = 16'd2;
        tbl[1] = 16'd4; tbl[2] = 16'd3; tbl[3] = 16'd2;
        tbl[4] = 16'd9; tbl[5] = 16'd3; tbl[6] = 16'd8;
        run_scan(0, 0, 0, 16'd0, cyc);
        check_results("tie", cyc, 15, 16'd4, 16'd3, 16'd2, 16'd2, 1'b1);

        // Case 4: four-cycle grant loss while addressing entry 1's Q-value
        load_case1();
        run_scan(11, 4, 0, 16'h0105, cyc);
        check_results("stall", cyc, 25, 16'd7, 16'd3, 16'd5, 16'd1, 1'b1);

        // Case 5: reset in the middle of entry 1, then a clean rescan
        run_scan(0, 0, 10, 16'd0, cyc);
        seen = 1'b0;
        repeat (30) begin
            @(posedge clock);
            #1;
            if (done) seen = 1'b1;
        end
        check("no_done_after_reset", seen, 1'b0);
        run_scan(0, 0, 0, 16'd0, cyc);
        check_results("rescan", cyc, 21, 16'd7, 16'd3, 16'd5, 16'd1, 1'b1);

        // Case 6: this node's own ID appears in the table
        my_node_id = 16'd7;
        run_scan(0, 0, 0, 16'd0, cyc);
`ifdef SELF_FILTER_EN
        check_results("self", cyc, 21, 16'd2, 16'd6, 16'd1, 16'd0, 1'b1);
`else
        check_results("self", cyc, 21, 16'd7, 16'd3, 16'd5, 16'd1, 1'b1);
`endif

        // Case 7: header count above MAX_NBR; entry 18 would win if scanned
        tbl[0] = 16'd20;
        for (int k = 0; k < 20; k++) begin
            tbl[1 + 3*k] = 16'(k + 1);
            tbl[2 + 3*k] = 16'(100 + k);
            tbl[3 + 3*k] = 16'(k);
        end
        tbl[2 + 3*18] = 16'd1;
        my_qvalue = 16'd105; my_node_id = 16'd0;
        run_scan(0, 0, 0, 16'd0, cyc);
        check_results("clamp", cyc, 99, 16'd1, 16'd100, 16'd0, 16'd5, 1'b1);

        // Randomized tables, operands and grant pattern
        @(negedge clock);
        rand_gnt = 1'b1;
        for (int it = 0; it < 40; it++) begin
            int n, t;
            n = $urandom_range(0, 20);
            tbl[0] = 16'(n);
            for (int i = 1; i <= 3 * n; i++) begin
                case ((i - 1) % 3)
                    0: tbl[i] = 16'($urandom_range(0, 15));
                    1: tbl[i] = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom_range(0, 40));
                    default: tbl[i] = 16'($urandom);
                endcase
            end
            my_qvalue  = 16'($urandom_range(0, 40));
            my_node_id = 16'($urandom_range(0, 15));
            start = 1'b1;
            repeat ($urandom_range(1, 5)) @(negedge clock);
            start = 1'b0;
            t = 0;
            while (m_busy && t < 2000) begin
                @(negedge clock);
                t++;
            end
            if (t >= 2000) check("random_timeout", 32'd0, 32'd1);
            @(negedge clock);
        end

        rand_gnt = 1'b0;
        repeat (2) @(negedge clock);
        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
